// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between a multicycle datapath and its sequencer.
// The sequencer side uses the slave modport; the datapath/decoder side uses master.
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             halt_op;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             branch;
    logic             uncond_branch;
    logic             imem_ready;
    logic             dmem_ready;
    logic             ir_we;
    logic             pc_we;
    logic             regfile_we;
    logic             dmem_re;
    logic             dmem_we;
    logic [2:0]       state;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output start, halt_op, memread, memwrite, regwrite, branch, uncond_branch,
        output imem_ready, dmem_ready,
        input  ir_we, pc_we, regfile_we, dmem_re, dmem_we,
        input  state, busy, err, retired, stall_cycles
    );

    modport slave (
        input  start, halt_op, memread, memwrite, regwrite, branch, uncond_branch,
        input  imem_ready, dmem_ready,
        output ir_we, pc_we, regfile_we, dmem_re, dmem_we,
        output state, busy, err, retired, stall_cycles
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer FSM with wait timeout and optional performance
// counters (enabled by defining SEQ_PERF_COUNTERS_EN).
module multicycle_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                    CLK,
    input  logic                    resetl,
    multicycle_sequencer_if.slave   bus
);
    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              err_r;
    logic              ir_we_r;
    logic              pc_we_r;
    logic              regfile_we_r;
    logic              dmem_re_r;
    logic              dmem_we_r;
    logic              memread_l_r;
    logic              memwrite_l_r;
    logic              regwrite_l_r;
    logic              branch_l_r;
    logic              uncond_l_r;
    logic              wait_expired_s;

    assign wait_expired_s = (wait_cnt_r == WAIT_W'(WAIT_LIMIT - 1));

    // Sequencer FSM; strobes are registered and appear in the cycle after the
    // deciding edge, except WB's strobes which are loaded on entry to WB.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_r      <= S_IDLE;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            err_r        <= 1'b0;
            ir_we_r      <= 1'b0;
            pc_we_r      <= 1'b0;
            regfile_we_r <= 1'b0;
            dmem_re_r    <= 1'b0;
            dmem_we_r    <= 1'b0;
            memread_l_r  <= 1'b0;
            memwrite_l_r <= 1'b0;
            regwrite_l_r <= 1'b0;
            branch_l_r   <= 1'b0;
            uncond_l_r   <= 1'b0;
        end else begin
            ir_we_r      <= 1'b0;
            pc_we_r      <= 1'b0;
            regfile_we_r <= 1'b0;
            dmem_re_r    <= 1'b0;
            dmem_we_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r    <= S_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        ir_we_r <= 1'b1;
                        state_r <= S_DECODE;
                    end else if (wait_expired_s) begin
                        state_r <= S_HALT;
                        err_r   <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    memread_l_r  <= bus.memread;
                    memwrite_l_r <= bus.memwrite;
                    regwrite_l_r <= bus.regwrite;
                    branch_l_r   <= bus.branch;
                    uncond_l_r   <= bus.uncond_branch;
                    state_r      <= bus.halt_op ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (branch_l_r || uncond_l_r) begin
                        pc_we_r    <= 1'b1;
                        state_r    <= S_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else if (memread_l_r || memwrite_l_r) begin
                        // A load+store combination is treated as a load.
                        dmem_re_r  <= memread_l_r;
                        dmem_we_r  <= memwrite_l_r & ~memread_l_r;
                        state_r    <= S_MEM;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else if (regwrite_l_r) begin
                        regfile_we_r <= 1'b1;
                        pc_we_r      <= 1'b1;
                        state_r      <= S_WB;
                    end else begin
                        pc_we_r    <= 1'b1;
                        state_r    <= S_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        if (memread_l_r) begin
                            regfile_we_r <= 1'b1;
                            pc_we_r      <= 1'b1;
                            state_r      <= S_WB;
                        end else begin
                            pc_we_r    <= 1'b1;
                            state_r    <= S_FETCH;
                            wait_cnt_r <= {WAIT_W{1'b0}};
                        end
                    end else if (wait_expired_s) begin
                        state_r <= S_HALT;
                        err_r   <= 1'b1;
                    end else begin
                        dmem_re_r  <= memread_l_r;
                        dmem_we_r  <= memwrite_l_r & ~memread_l_r;
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state_r    <= S_FETCH;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r <= S_HALT;
                    err_r   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ir_we      = ir_we_r;
    assign bus.pc_we      = pc_we_r;
    assign bus.regfile_we = regfile_we_r;
    assign bus.dmem_re    = dmem_re_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.state      = state_r;
    assign bus.err        = err_r;
    assign bus.busy       = (state_r != S_IDLE) && (state_r != S_HALT);

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] stall_r;
    logic             stall_s;

    assign stall_s = ((state_r == S_FETCH) && !bus.imem_ready) ||
                     ((state_r == S_MEM)   && !bus.dmem_ready);

    // Saturating retire/stall counters.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            retired_r <= {CNT_W{1'b0}};
            stall_r   <= {CNT_W{1'b0}};
        end else begin
            if (pc_we_r && (retired_r != {CNT_W{1'b1}})) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            if (stall_s && (stall_r != {CNT_W{1'b1}})) begin
                stall_r <= stall_r + CNT_W'(1);
            end
        end
    end

    assign bus.retired      = retired_r;
    assign bus.stall_cycles = stall_r;
`else
    assign bus.retired      = {CNT_W{1'b0}};
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule
